// File: rtl/bcd_display_pkg.sv
// -----------------------------------------------------------------------------
// bcd_display_pkg
// Shared definitions for the multiplexed BCD seven-segment display block:
//   - scanState_t : scanner FSM states (IDLE = nothing received yet, SCAN)
//   - SEG_0..SEG_9: active-high segment patterns, bit0 = a ... bit6 = g
//   - SEG_DASH    : pattern shown for the non-decimal codes 10..15
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scanState_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// -----------------------------------------------------------------------------
// bcd_seg_scan_if
// Bundles the digit-source side and the display-drive side of bcd_seg_scan.
//   digitsIn    [numberOfDigits-1:0][3:0] BCD digits, index 0 = least significant
//   digitsValid 1                         single-cycle strobe, digitsIn complete
//   segOut      7                         segment pattern, active-high
//   digitSel    numberOfDigits            one-hot active-high digit enable
//   frameStart  1                         pulse on the first cycle of a frame
// Modports: master = digit source / display consumer, slave = the scanner.
// -----------------------------------------------------------------------------
interface bcd_seg_scan_if #(
  parameter int numberOfDigits = 3
);

  logic [numberOfDigits-1:0][3:0] digitsIn;
  logic                           digitsValid;
  logic [6:0]                     segOut;
  logic [numberOfDigits-1:0]      digitSel;
  logic                           frameStart;

  modport master (
    output digitsIn,
    output digitsValid,
    input  segOut,
    input  digitSel,
    input  frameStart
  );

  modport slave (
    input  digitsIn,
    input  digitsValid,
    output segOut,
    output digitSel,
    output frameStart
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to seven-segment decoder. Codes 10..15 are not
// decimal digits and show a dash so a converter fault is visible on the panel.
//   bcd [3:0] in  : BCD code
//   seg [6:0] out : active-high segments, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Code to segment pattern lookup.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seg_scan
// Time-multiplexed driver for a numberOfDigits-digit common seven-segment
// display. Digits are scanned from the most significant (numberOfDigits-1)
// down to 0; each digit is selected for scanDivider clocks, the first of which
// is an all-off dead cycle against ghosting. New results are double-buffered
// so a frame always shows one consistent value.
//
// Parameters:
//   numberOfDigits (>= 2)  number of BCD digits
//   scanDivider    (>= 4)  clocks per digit slot
// Ports:
//   clk  in   single clock, all logic on its rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of bcd_seg_scan_if (digitsIn/digitsValid in,
//        segOut/digitSel/frameStart out, all outputs registered)
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, zero digits above the most
//                          significant nonzero digit are blanked (digit 0 is
//                          never blanked; digitSel still scans them).
// -----------------------------------------------------------------------------
module bcd_seg_scan
  import bcd_display_pkg::*;
#(
  parameter int numberOfDigits = 3,
  parameter int scanDivider    = 1000
) (
  input logic           clk,
  input logic           rst,
  bcd_seg_scan_if.slave bus
);

  localparam int PW = $clog2(scanDivider);
  localparam int IW = $clog2(numberOfDigits);
  localparam logic [PW-1:0] PRE_LAST = PW'(scanDivider - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(numberOfDigits - 1);

  scanState_t                     state_r;
  logic [PW-1:0]                  prescaler_r;
  logic [IW-1:0]                  digitIdx_r;
  logic [numberOfDigits-1:0][3:0] displayReg_r;
  logic [numberOfDigits-1:0][3:0] pendingReg_r;
  logic                           pendingFlag_r;
  logic [6:0]                     segOut_r;
  logic [numberOfDigits-1:0]      digitSel_r;
  logic                           frameStart_r;

  logic [3:0]                     curDigit_s;
  logic [6:0]                     decoded_s;
  logic [numberOfDigits-1:0]      blankMask_s;
  logic [6:0]                     segNext_s;
  logic [numberOfDigits-1:0]      selNext_s;

  assign curDigit_s = displayReg_r[digitIdx_r];

  bcd_to_seg7 u_decode (
    .bcd (curDigit_s),
    .seg (decoded_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Mark each upper digit whose own value and every digit above it are zero.
  always_comb begin : leadBlank
    logic zerosAbove;
    zerosAbove  = 1'b1;
    blankMask_s = '0;
    for (int i = numberOfDigits - 1; i >= 1; i--) begin
      zerosAbove     = zerosAbove & (displayReg_r[i] == 4'd0);
      blankMask_s[i] = zerosAbove;
    end
  end
`else
  assign blankMask_s = '0;
`endif

  // Next output pattern from the current index/prescaler; prescaler 0 is dead time.
  always_comb begin
    segNext_s = 7'd0;
    selNext_s = '0;
    if (state_r == SCAN) begin
      if (blankMask_s[digitIdx_r]) begin
        segNext_s = 7'd0;
      end else begin
        segNext_s = decoded_s;
      end
      if (prescaler_r != '0) begin
        selNext_s[digitIdx_r] = 1'b1;
      end else begin
        selNext_s = '0;
      end
    end else begin
      segNext_s = 7'd0;
      selNext_s = '0;
    end
  end

  // Scanner FSM, double buffer and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      prescaler_r   <= '0;
      digitIdx_r    <= IDX_TOP;
      displayReg_r  <= '0;
      pendingReg_r  <= '0;
      pendingFlag_r <= 1'b0;
      segOut_r      <= 7'd0;
      digitSel_r    <= '0;
      frameStart_r  <= 1'b0;
    end else begin
      segOut_r   <= segNext_s;
      digitSel_r <= selNext_s;
      case (state_r)
        IDLE: begin
          // The very first result goes straight to the display.
          if (bus.digitsValid) begin
            displayReg_r <= bus.digitsIn;
            state_r      <= SCAN;
            prescaler_r  <= '0;
            digitIdx_r   <= IDX_TOP;
            frameStart_r <= 1'b1;
          end else begin
            frameStart_r <= 1'b0;
          end
        end
        SCAN: begin
          frameStart_r <= 1'b0;
          if (prescaler_r == PRE_LAST) begin
            prescaler_r <= '0;
            if (digitIdx_r == '0) begin
              // Frame boundary: the only point where the shown value may change.
              digitIdx_r   <= IDX_TOP;
              frameStart_r <= 1'b1;
              if (pendingFlag_r) begin
                displayReg_r  <= pendingReg_r;
                pendingFlag_r <= 1'b0;
              end
            end else begin
              digitIdx_r <= digitIdx_r - IW'(1);
            end
          end else begin
            prescaler_r <= prescaler_r + PW'(1);
          end
          // Placed last so a strobe on the boundary edge re-arms pending
          // after the copy above (last assignment wins).
          if (bus.digitsValid) begin
            pendingReg_r  <= bus.digitsIn;
            pendingFlag_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.segOut     = segOut_r;
  assign bus.digitSel   = digitSel_r;
  assign bus.frameStart = frameStart_r;

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 SHALL have parameter numberOfDigits, default 3, number of BCD digits displayed (min 2).
REQ-002 SHALL have parameter scanDivider, default 1000, clk cycles each digit is selected (min 4).
REQ-003 SHALL have port clk  input  1  the only clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port digitsIn  input  [numberOfDigits-1:0][3:0]  BCD digits from the binary-to-BCD converter, index 0 = least significant.
REQ-006 SHALL have port digitsValid  input  1  single-cycle strobe marking digitsIn as a complete result.
REQ-007 SHALL have port segOut  output  7  segment pattern, active-high, bit0=a ... bit6=g.
REQ-008 SHALL have port digitSel  output  numberOfDigits  one-hot active-high digit enable.
REQ-009 SHALL have port frameStart  output  1  one-cycle pulse when a scan frame begins.

Function
REQ-010 SHALL use FSM states IDLE (no data received) and SCAN.
REQ-011 In IDLE, SHALL drive digitSel=0 and segOut=0; on the first digitsValid, SHALL load the display register and enter SCAN on the next cycle.
REQ-012 In SCAN, SHALL use a prescaler counting 0..scanDivider-1 and wrapping; each wrap advances the digit index.
REQ-013 SHALL scan the index downward from numberOfDigits-1 to 0, wrapping to numberOfDigits-1; the wrap marks the frame boundary.
REQ-014 While prescaler==0, SHALL drive digitSel=0 as anti-ghosting dead time; otherwise digitSel SHALL be one-hot at the current index.
REQ-015 In SCAN, digitsValid SHALL load a pending register and set a pending flag; a later strobe before the boundary SHALL overwrite it (last wins).
REQ-016 At the frame boundary, if pending is set, SHALL copy pending to the display register and clear the flag in the same cycle; the displayed value SHALL never change mid-frame.
REQ-017 If digitsValid coincides with the boundary, the new digits SHALL go to pending and display from the following frame.
REQ-018 frameStart SHALL pulse on the first cycle of each frame, including the SCAN entry cycle.
REQ-019 segOut decode: 0-9 -> 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F; codes 10-15 -> 0x40 (dash).
REQ-020 segOut and digitSel SHALL be registered, one cycle after the index and prescaler they reflect.

Reset
REQ-021 rst SHALL force IDLE, prescaler=0, index=numberOfDigits-1, pending flag=0, display and pending registers=0, segOut=0, digitSel=0, frameStart=0.
REQ-022 rst mid-frame SHALL discard pending data; digitsValid in the rst cycle SHALL be ignored.

Configuration
REQ-023 With macro LEADING_ZERO_BLANK_EN defined, zero digits above the most significant nonzero digit SHALL show segOut=0 (digitSel still active); digit 0 SHALL never be blanked.
REQ-024 Without LEADING_ZERO_BLANK_EN, every digit SHALL be decoded per REQ-019.

Structure
REQ-025 SHALL place the FSM state enum and the ten segment constants plus the dash constant in shared package bcd_display_pkg.
REQ-026 SHALL implement the 4-to-7 decode as combinational sub-module bcd_to_seg7.

Verification
REQ-027 Reset then no strobe for 5000 cycles -> digitSel=0, segOut=0, frameStart never pulses.
REQ-028 numberOfDigits=3, scanDivider=8, digitsIn={1,2,3} strobe -> frames show digitSel 100/0x06, 010/0x5B, 001/0x4F; each dwell 7 active cycles after 1 dead cycle; frameStart every 24 cycles.
REQ-029 Strobe {4,5,6} mid-frame, then {7,8,9} two cycles later -> current frame unchanged; next frame shows 7,8,9; 4,5,6 never shown.
REQ-030 Digits {0,0,5}: with LEADING_ZERO_BLANK_EN -> segOut 0x00,0x00,0x6D; without -> 0x3F,0x3F,0x6D. Digits {0,0,0} with the macro -> last digit 0x3F.
REQ-031 Digit code 12 -> segOut 0x40 for that digit.
REQ-032 rst asserted mid-dwell with pending set -> next cycle IDLE, outputs 0; next strobe restarts with frameStart.
